punct_conv_encoder: RTL and testbench
=====================================

PUNCT_CONV_ENCODER -- requirements
Module: punct_conv_encoder

Interface
REQ-001 SHALL have parameter MAX_K, default 9, meaning maximum constraint length supported.
REQ-002 SHALL have parameter MAX_RATE, default 3, meaning maximum output bits per input bit (rate 1/MAX_RATE).
REQ-003 SHALL have parameter FRAME_LEN, default 16, meaning data bits per frame before tail insertion.
REQ-004 SHALL use one clock and an asynchronous active-low reset; sys_clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-low reset.
REQ-006 en  in  1  global enable; low freezes all state and outputs (no handshake progress).
REQ-007 i_code_rate  in  1  0 = rate 1/2 (gen_poly[0..1]), 1 = rate 1/3 (gen_poly[0..2]).
REQ-008 i_constr_len  in  2  0:K=3, 1:K=5, 2:K=7, 3:K=9.
REQ-009 i_gen_poly  in  MAX_RATE x MAX_K  generator polynomials; bit i taps the input delayed i cycles.
REQ-010 i_punct_en  in  1  1 = puncture rate 1/2 to rate 2/3; ignored when i_code_rate=1.
REQ-011 i_bit / i_valid / o_ready  in/in/out  1/1/1  input bit stream handshake.
REQ-012 o_symbol  out  MAX_RATE  encoder outputs, o_symbol[j] from gen_poly[j]; unused bits 0.
REQ-013 o_sym_mask  out  MAX_RATE  1 per o_symbol bit actually transmitted (after puncturing).
REQ-014 o_valid / i_ready / o_last  out/in/out  1/1/1  output symbol handshake; o_last marks final tail symbol.
REQ-015 o_done  out  1  one-cycle pulse after the frame's last symbol is accepted.

Function
REQ-016 FSM states SHALL be IDLE, DATA, TAIL, DONE; reset enters IDLE.
REQ-017 IDLE->DATA on first en cycle; i_code_rate, i_constr_len, i_gen_poly, i_punct_en latched at that transition and held for the frame.
REQ-018 Input transfer occurs when i_valid && o_ready; o_ready = en && state==DATA && (!o_valid || i_ready).
REQ-019 Per transferred bit: r[0]=bit, r[i]=bit i transfers ago; o_symbol[j] = XOR over i<K of gen_poly[j][i] & r[i]; taps i>=K ignored.
REQ-020 Latency SHALL be one cycle: o_symbol/o_valid registered on the cycle after transfer.
REQ-021 o_valid with stalled i_ready SHALL hold o_symbol, o_sym_mask, o_last stable until accepted.
REQ-022 After FRAME_LEN data transfers, DATA->TAIL; TAIL injects K-1 zero bits internally, o_ready=0, one per cycle subject to output backpressure.
REQ-023 o_last=1 on the K-1th tail symbol; TAIL->DONE when it is accepted; DONE pulses o_done one cycle, clears shift register and symbol counter, returns to IDLE.
REQ-024 o_sym_mask: rate 1/2 -> 011; rate 1/3 -> 111; punctured -> symbol index even 011, odd 001 (index counts data and tail symbols from 0 per frame).
REQ-025 Frame of FRAME_LEN + K-1 symbols SHALL always complete; i_valid during TAIL/DONE/IDLE is ignored, not buffered.
REQ-026 Config input changes mid-frame SHALL have no effect until the next IDLE->DATA.

Reset
REQ-027 rst low SHALL asynchronously clear shift register, counters, latched config, o_symbol, o_sym_mask, o_valid, o_last, o_done, o_ready to 0 and state to IDLE, aborting any frame in progress.
REQ-028 After rst release the first frame SHALL start clean with all-zero encoder state.

Structure
REQ-029 MAX_K, MAX_RATE, code-rate and constraint-length encodings and the FSM state enum SHALL live in the shared param_def package.
REQ-030 Parity computation SHALL be a sub-module conv_parity (one instance per output, combinational, parametrised by MAX_K).

Verification
REQ-031 K=3, rate 1/2, polys 111/101, FRAME_LEN=4, input 1011, i_ready=1 -> (o_symbol[0],o_symbol[1]) 11,10,00,01,01,11; o_last on 6th; o_done next cycle.
REQ-032 Same with i_punct_en=1 -> identical symbols, masks 011,001,011,001,011,001.
REQ-033 Same stimulus, i_ready low for 3 cycles at symbol 2 -> symbol 2 held stable, o_ready=0 during stall, sequence unchanged.
REQ-034 Rate 1/3, K=3, polys 111/101/011, input 1 then zeros -> first symbol mask 111, o_symbol 111 (bits 0..2).
REQ-035 rst low during TAIL -> all outputs 0 immediately; next frame 1011 reproduces REQ-031 exactly.
REQ-036 Change i_constr_len mid-frame -> current frame still emits K-1=2 tail symbols of original K.

Source files
------------

// File: rtl/param_def.sv
// param_def: shared limits, config encodings and FSM states for the punctured convolutional encoder
package param_def;
  localparam int MAX_K = 9;
  localparam int MAX_RATE = 3;
  typedef enum logic {RATE_1_2 = 1'b0, RATE_1_3 = 1'b1} rate_t;
  typedef enum logic [1:0] {K3 = 2'd0, K5 = 2'd1, K7 = 2'd2, K9 = 2'd3} constr_t;
  typedef enum logic [1:0] {IDLE, DATA, TAIL, DONE} state_t;
  function automatic int k_of(input logic [1:0] cl);
    return 3 + 2 * int'(cl);
  endfunction
endpackage

// File: rtl/conv_parity.sv
// conv_parity: XOR of the shift-register bits selected by one generator polynomial
module conv_parity #(
  parameter int MAX_K = 9
) (
  input  logic [MAX_K-1:0] poly,
  input  logic [MAX_K-1:0] sreg,
  output logic             parity
);
  always_comb parity = ^(poly & sreg);
endmodule

// File: rtl/punct_conv_encoder.sv
// punct_conv_encoder: framed rate 1/2 or 1/3 convolutional encoder with optional 2/3 puncturing and zero-tail flush
module punct_conv_encoder #(
  parameter int MAX_K     = param_def::MAX_K,
  parameter int MAX_RATE  = param_def::MAX_RATE,
  parameter int FRAME_LEN = 16
) (
  input  logic                      sys_clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      i_code_rate,
  input  logic [1:0]                i_constr_len,
  input  logic [MAX_RATE*MAX_K-1:0] i_gen_poly,
  input  logic                      i_punct_en,
  input  logic                      i_bit,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic [MAX_RATE-1:0]       o_symbol,
  output logic [MAX_RATE-1:0]       o_sym_mask,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_last,
  output logic                      o_done
);
  import param_def::*;
  localparam int CW = $clog2(FRAME_LEN + MAX_K);
  state_t state;
  logic rate, punct, adv, load, shift_in;
  logic [1:0] cl;
  logic [MAX_RATE*MAX_K-1:0] poly;
  logic [MAX_K-2:0] sreg;
  logic [MAX_K-1:0] nxt, taps;
  logic [MAX_RATE-1:0] par, rmask, mask;
  logic [CW-1:0] sidx;
  int k;
  always_comb begin
    k = k_of(cl);
    for (int i = 0; i < MAX_K; i++) taps[i] = i < k;
    for (int i = 0; i < MAX_RATE; i++) rmask[i] = i < (rate ? 3 : 2);
    mask = (!rate && punct && sidx[0]) ? MAX_RATE'(1) : rmask;
    adv = en && (!o_valid || i_ready);
    o_ready = adv && state == DATA;
    shift_in = state == DATA && i_bit;
    nxt = {sreg, shift_in};
    load = (o_ready && i_valid) || (state == TAIL && adv && !o_last);
  end
  // parity is taken on the register as it will be after this shift
  for (genvar j = 0; j < MAX_RATE; j++) begin : g_par
    conv_parity #(.MAX_K(MAX_K)) u_par (
      .poly(poly[j*MAX_K +: MAX_K] & taps),
      .sreg(nxt),
      .parity(par[j])
    );
  end
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      {rate, punct, cl, poly, sreg, sidx} <= '0;
      {o_symbol, o_sym_mask, o_valid, o_last, o_done} <= '0;
    end else if (en) begin
      o_done <= 1'b0;
      if (o_valid && i_ready) {o_valid, o_last} <= 2'b00;
      case (state)
        IDLE: begin
          {rate, cl, poly, punct} <= {i_code_rate, i_constr_len, i_gen_poly, i_punct_en};
          state <= DATA;
        end
        DATA: if (load && int'(sidx) == FRAME_LEN - 1) state <= TAIL;
        TAIL: if (o_valid && o_last && i_ready) {state, o_done} <= {DONE, 1'b1};
        DONE: {state, sreg, sidx} <= {IDLE, {(MAX_K-1){1'b0}}, {CW{1'b0}}};
      endcase
      if (load) begin
        sreg <= nxt[MAX_K-2:0];
        o_symbol <= par & rmask;
        o_sym_mask <= mask;
        o_valid <= 1'b1;
        o_last <= state == TAIL && int'(sidx) == FRAME_LEN + k - 2;
        sidx <= sidx + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_punct_conv_encoder.sv
// tb_punct_conv_encoder: directed and randomized frames checked against a convolution-sum reference model
module tb_punct_conv_encoder;
  localparam int FL = 4, MK = 9, MR = 3;
  logic sys_clk = 0, rst = 1, en = 0, i_code_rate = 0, i_punct_en = 0, i_bit = 0, i_valid = 0, i_ready = 1;
  logic [1:0] i_constr_len = 0;
  logic [MR*MK-1:0] i_gen_poly = '0;
  logic o_ready, o_valid, o_last, o_done;
  logic [MR-1:0] o_symbol, o_sym_mask;
  int checks = 0, failures = 0;
  int rdy_mode = 0, stall_n = 0, cyc = 0, last_cyc = -1, done_cyc = -1, done_cnt = 0;
  int hold_viol = 0, ready_viol = 0, stall_cyc = 0;
  bit en_rand = 0, en_force = 0, clr = 0;
  logic pv = 0, pacc = 0, pl = 0, pdone = 0;
  logic [2:0] ps = 0, pm = 0;
  logic [2:0] got_sym[$], got_mask[$], exp_sym[$], exp_mask[$];
  bit got_last[$];
  logic [2:0] b_sym[6] = '{3'b011, 3'b001, 3'b000, 3'b010, 3'b010, 3'b011};
  localparam logic [26:0] GP_BASIC = {9'b0, 9'b000000101, 9'b000000111};
  localparam logic [26:0] GP_R3 = {9'b000000011, 9'b000000101, 9'b000000111};

  punct_conv_encoder #(.MAX_K(MK), .MAX_RATE(MR), .FRAME_LEN(FL)) dut (
    .sys_clk(sys_clk), .rst(rst), .en(en), .i_code_rate(i_code_rate), .i_constr_len(i_constr_len),
    .i_gen_poly(i_gen_poly), .i_punct_en(i_punct_en), .i_bit(i_bit), .i_valid(i_valid), .o_ready(o_ready),
    .o_symbol(o_symbol), .o_sym_mask(o_sym_mask), .o_valid(o_valid), .i_ready(i_ready), .o_last(o_last),
    .o_done(o_done)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    #1;
    en = en_rand ? ($urandom_range(3) != 0) : en_force;
    if (got_sym.size() == 0) stall_n = 0;
    case (rdy_mode)
      1: i_ready = $urandom_range(2) != 0;
      2: if (o_valid && got_sym.size() == 2 && stall_n < 3) begin i_ready = 0; stall_n++; end else i_ready = 1;
      3: i_ready = got_sym.size() < FL;
      default: i_ready = 1;
    endcase
  end

  always @(negedge sys_clk) begin
    if (clr) begin
      got_sym.delete(); got_mask.delete(); got_last.delete();
      hold_viol = 0; ready_viol = 0; stall_cyc = 0; last_cyc = -1; done_cyc = -1; done_cnt = 0;
    end
    cyc++;
    if (rst && pv && !pacc && (!o_valid || o_symbol !== ps || o_sym_mask !== pm || o_last !== pl)) hold_viol++;
    if (o_valid && !i_ready && o_ready) ready_viol++;
    if (en && o_valid && !i_ready) stall_cyc++;
    if (en && o_valid && i_ready) begin
      got_sym.push_back(o_symbol); got_mask.push_back(o_sym_mask); got_last.push_back(o_last);
      if (o_last) last_cyc = cyc;
    end
    if (o_done && !pdone) begin done_cnt++; done_cyc = cyc; end
    pv = rst && o_valid; pacc = en && o_valid && i_ready; ps = o_symbol; pm = o_sym_mask; pl = o_last; pdone = o_done;
  end

  // symbol t is the mod-2 convolution of each polynomial with the zero-padded data sequence
  task automatic build_exp(input bit rate, input bit [1:0] cl, input logic [26:0] gp, input bit pe, input bit [3:0] d);
    int kk, n;
    logic [2:0] s;
    kk = 3 + 2 * int'(cl);
    n = FL + kk - 1;
    exp_sym.delete(); exp_mask.delete();
    for (int t = 0; t < n; t++) begin
      s = '0;
      for (int j = 0; j < (rate ? 3 : 2); j++)
        for (int i = 0; i < kk; i++)
          if (t - i >= 0 && t - i < FL) s[j] = s[j] ^ (gp[j*9+i] & d[t-i]);
      exp_sym.push_back(s);
      exp_mask.push_back(rate ? 3'b111 : (pe && t % 2 == 1) ? 3'b001 : 3'b011);
    end
  endtask

  task automatic run_frame(input bit rate, input bit [1:0] cl, input logic [26:0] gp, input bit pe,
                           input bit [3:0] d, input int rmode, input bit enr, input bit scr, input bit wait_done);
    int g;
    bit x;
    @(posedge sys_clk); #2;
    i_valid = 0; en_force = 0; en_rand = 0; rdy_mode = rmode;
    repeat (2) @(posedge sys_clk);
    #2;
    i_code_rate = rate; i_constr_len = cl; i_gen_poly = gp; i_punct_en = pe;
    clr = 1;
    @(negedge sys_clk); #1;
    clr = 0; en_force = 1; en_rand = enr;
    for (int t = 0; t < FL; t++) begin
      i_valid = 1; i_bit = d[t]; g = 0;
      do begin
        @(negedge sys_clk); x = o_ready;
        @(posedge sys_clk); #2; g++;
      end while (!x && g < 300);
      if (scr && t == 0) begin
        i_code_rate = ~rate; i_constr_len = ~cl; i_gen_poly = 27'($urandom); i_punct_en = ~pe;
      end
    end
    i_bit = 1'($urandom);
    if (!wait_done) return;
    g = 0;
    while (done_cnt == 0 && g < 400) begin @(negedge sys_clk); #1; g++; end
    i_valid = 0; en_rand = 0; en_force = 0;
    checks++;
    if (done_cnt == 0) begin failures++; $display("FAIL frame_timeout done_cnt=%0d required>=1", done_cnt); end
  endtask

  task automatic test_reset;
    #3 rst = 0;
    #10;
    checks++;
    if ({o_valid, o_symbol, o_sym_mask, o_last, o_done, o_ready} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b/%b/%b/%b/%b/%b required all 0", o_valid, o_symbol, o_sym_mask, o_last, o_done, o_ready);
    end
    #10 rst = 1;
    repeat (2) @(negedge sys_clk);
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b0) begin failures++; $display("FAIL reset_idle valid=%b ready=%b required 0/0", o_valid, o_ready); end
  endtask

  task automatic test_basic;
    run_frame(0, 0, GP_BASIC, 0, 4'b1101, 0, 0, 0, 1);
    checks++;
    if (got_sym.size() != 6) begin failures++; $display("FAIL basic_len got=%0d required=6", got_sym.size()); end
    for (int i = 0; i < got_sym.size() && i < 6; i++) begin
      checks++;
      if (got_sym[i] !== b_sym[i] || got_mask[i] !== 3'b011 || got_last[i] !== (i == 5)) begin
        failures++;
        $display("FAIL basic_sym%0d got=%b/%b/%b required=%b/011/%b", i, got_sym[i], got_mask[i], got_last[i], b_sym[i], i == 5);
      end
    end
    checks++;
    if (done_cyc !== last_cyc + 1) begin failures++; $display("FAIL basic_done cyc=%0d required=%0d", done_cyc, last_cyc + 1); end
  endtask

  task automatic test_punct;
    run_frame(0, 0, GP_BASIC, 1, 4'b1101, 0, 0, 0, 1);
    checks++;
    if (got_sym.size() != 6) begin failures++; $display("FAIL punct_len got=%0d required=6", got_sym.size()); end
    for (int i = 0; i < got_sym.size() && i < 6; i++) begin
      checks++;
      if (got_sym[i] !== b_sym[i] || got_mask[i] !== (i % 2 ? 3'b001 : 3'b011)) begin
        failures++;
        $display("FAIL punct_sym%0d got=%b/%b required=%b/%b", i, got_sym[i], got_mask[i], b_sym[i], i % 2 ? 3'b001 : 3'b011);
      end
    end
  endtask

  task automatic test_stall;
    run_frame(0, 0, GP_BASIC, 0, 4'b1101, 2, 0, 0, 1);
    checks++;
    if (got_sym.size() != 6) begin failures++; $display("FAIL stall_len got=%0d required=6", got_sym.size()); end
    for (int i = 0; i < got_sym.size() && i < 6; i++) begin
      checks++;
      if (got_sym[i] !== b_sym[i]) begin failures++; $display("FAIL stall_sym%0d got=%b required=%b", i, got_sym[i], b_sym[i]); end
    end
    checks++;
    if (stall_cyc != 3 || ready_viol != 0 || hold_viol != 0) begin
      failures++;
      $display("FAIL stall_hold stall=%0d ready_during_stall=%0d unstable=%0d required 3/0/0", stall_cyc, ready_viol, hold_viol);
    end
  endtask

  task automatic test_rate3;
    run_frame(1, 0, GP_R3, 0, 4'b0001, 0, 0, 0, 1);
    build_exp(1, 0, GP_R3, 0, 4'b0001);
    checks++;
    if (got_sym.size() == 0 || got_sym[0] !== 3'b111 || got_mask[0] !== 3'b111) begin
      failures++;
      $display("FAIL rate3_first got=%b/%b required=111/111", got_sym.size() ? got_sym[0] : 3'bx, got_mask.size() ? got_mask[0] : 3'bx);
    end
    for (int i = 0; i < got_sym.size() && i < exp_sym.size(); i++) begin
      checks++;
      if (got_sym[i] !== exp_sym[i] || got_mask[i] !== exp_mask[i]) begin
        failures++;
        $display("FAIL rate3_sym%0d got=%b/%b required=%b/%b", i, got_sym[i], got_mask[i], exp_sym[i], exp_mask[i]);
      end
    end
  endtask

  task automatic test_reset_tail;
    run_frame(0, 0, GP_BASIC, 0, 4'b1101, 3, 0, 0, 0);
    repeat (3) @(negedge sys_clk);
    checks++;
    if (got_sym.size() != FL || o_valid !== 1'b1) begin
      failures++; $display("FAIL tail_pending accepted=%0d valid=%b required=%0d/1", got_sym.size(), o_valid, FL);
    end
    #2 rst = 0;
    #1;
    checks++;
    if ({o_valid, o_symbol, o_sym_mask, o_last, o_done, o_ready} !== '0) begin
      failures++;
      $display("FAIL tail_reset got=%b/%b/%b/%b/%b/%b required all 0", o_valid, o_symbol, o_sym_mask, o_last, o_done, o_ready);
    end
    i_valid = 0; en_force = 0;
    @(negedge sys_clk); #2 rst = 1;
    run_frame(0, 0, GP_BASIC, 0, 4'b1101, 0, 0, 0, 1);
    checks++;
    if (got_sym.size() != 6) begin failures++; $display("FAIL after_reset_len got=%0d required=6", got_sym.size()); end
    for (int i = 0; i < got_sym.size() && i < 6; i++) begin
      checks++;
      if (got_sym[i] !== b_sym[i] || got_last[i] !== (i == 5)) begin
        failures++; $display("FAIL after_reset_sym%0d got=%b/%b required=%b/%b", i, got_sym[i], got_last[i], b_sym[i], i == 5);
      end
    end
  endtask

  task automatic test_cfg_change;
    run_frame(0, 0, GP_BASIC, 0, 4'b1101, 0, 0, 1, 1);
    checks++;
    if (got_sym.size() != 6 || got_last[got_sym.size()-1] !== 1'b1) begin
      failures++; $display("FAIL cfg_change_len got=%0d required=6 with last", got_sym.size());
    end
    for (int i = 0; i < got_sym.size() && i < 6; i++) begin
      checks++;
      if (got_sym[i] !== b_sym[i] || got_mask[i] !== 3'b011) begin
        failures++; $display("FAIL cfg_change_sym%0d got=%b/%b required=%b/011", i, got_sym[i], got_mask[i], b_sym[i]);
      end
    end
  endtask

  task automatic test_random;
    bit r, pe;
    bit [1:0] cl;
    bit [3:0] d;
    logic [26:0] gp;
    for (int f = 0; f < 25; f++) begin
      r = 1'($urandom); pe = 1'($urandom); cl = 2'($urandom); d = 4'($urandom); gp = 27'($urandom);
      run_frame(r, cl, gp, pe, d, 1, 1, 1, 1);
      build_exp(r, cl, gp, pe, d);
      checks++;
      if (got_sym.size() != exp_sym.size()) begin
        failures++; $display("FAIL rand%0d_len got=%0d required=%0d", f, got_sym.size(), exp_sym.size());
      end
      for (int i = 0; i < got_sym.size() && i < exp_sym.size(); i++) begin
        checks++;
        if (got_sym[i] !== exp_sym[i] || got_mask[i] !== exp_mask[i] || got_last[i] !== (i == exp_sym.size() - 1)) begin
          failures++;
          $display("FAIL rand%0d_sym%0d got=%b/%b/%b required=%b/%b/%b", f, i, got_sym[i], got_mask[i], got_last[i],
                   exp_sym[i], exp_mask[i], i == exp_sym.size() - 1);
        end
      end
      checks++;
      if (done_cyc !== last_cyc + 1 || hold_viol != 0) begin
        failures++; $display("FAIL rand%0d_done done=%0d last=%0d unstable=%0d", f, done_cyc, last_cyc, hold_viol);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_punct;
    test_stall;
    test_rate3;
    test_reset_tail;
    test_cfg_change;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
